i2c_master_write_bit: RTL and testbench
=======================================

I2C_MASTER_WRITE_BIT -- requirements
Module: i2c_master_write_bit

Interface
REQ-001 SHALL have parameter QUARTER, default 4: system clock cycles per quarter bit period; legal range 1 to 255.
REQ-002 SHALL have port clock, input, 1 bit: single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port go, input, 1 bit: request; level-held until finish is seen.
REQ-005 SHALL have port command, input, 3 bits, with these encodings:
- 010 START
- 011 STOP
- 100 DATA0
- 101 DATA1
- 110 ACK (sda=0)
- 111 NACK (sda=1)
- 000 and 001 invalid
REQ-006 SHALL have port finish, output, 1 bit: operation complete; registered.
REQ-007 SHALL have port scl, output, 1 bit: driven serial clock level, where 1 means released/high; registered.
REQ-008 SHALL have port sda, output, 1 bit: driven serial data level; registered.

Function
REQ-009 SHALL implement an FSM with states IDLE, RUN and DONE, a 2-bit phase counter (Q0..Q3) and a quarter-cycle divider counter.
REQ-010 In IDLE with go=1 and a valid command, the FSM SHALL latch command, enter RUN at phase Q0 and clear the divider on the same edge.
- command changes after acceptance are ignored.
REQ-011 Each phase SHALL last exactly QUARTER cycles, so RUN lasts 4*QUARTER cycles.
REQ-012 The scl/sda levels per phase (Q0/Q1/Q2/Q3) SHALL be:
- START: scl 1/1/1/0; sda 1/1/0/0.
- STOP: scl 0/1/1/1; sda 0/0/1/1.
- DATA0, DATA1, ACK, NACK: scl 0/1/1/0; sda constant at the bit value for all four phases (0 for DATA0/ACK, 1 for DATA1/NACK).
REQ-013 sda SHALL change only while scl=0, except the START Q2 falling edge and the STOP Q2 rising edge.
REQ-014 After the last Q3 cycle the FSM SHALL enter DONE with finish=1, and scl/sda SHALL hold the Q3 levels.
REQ-015 DONE SHALL persist while go=1; go=0 in DONE SHALL return the FSM to IDLE with finish=0 on the next edge.
REQ-016 If go drops during RUN, the operation SHALL still complete; finish is then high for exactly one cycle.
REQ-017 In IDLE, scl and sda SHALL hold their last driven levels, and finish SHALL be 0.
REQ-018 An invalid command with go=1 in IDLE SHALL enter DONE on the next edge (finish=1) with no change to scl or sda.
REQ-019 go=0 in IDLE SHALL produce no state change.

Reset
REQ-020 reset_n=0 SHALL immediately force IDLE, scl=1, sda=1 and finish=0, and clear the phase, divider and latched command.
- This applies at any point, including mid-operation.
REQ-021 After reset_n deasserts, the first go SHALL be accepted on the first rising edge where it is sampled high.

Configuration
REQ-022 With macro I2C_WRITE_BIT_CMD_ERR_EN defined, the block SHALL add output cmd_err (1 bit):
- cmd_err is set with finish in DONE for an invalid command, otherwise 0;
- it clears together with finish;
- reset value is 0.
REQ-023 Without I2C_WRITE_BIT_CMD_ERR_EN, the cmd_err port and its logic SHALL be absent, and invalid commands SHALL behave per REQ-018 only.

Verification
All scenarios use QUARTER=4, with cycles counted from the edge entering RUN; "at cycle N" means the value from cycle N onward.

REQ-024 START: reset, then go=1, command=010.
- scl=1 and sda=1 for cycles 0-7;
- sda=0 at cycle 8, with scl still 1;
- scl=0 at cycle 12;
- finish=1 at cycle 16, held until go=0, then 0 one cycle later.
REQ-025 STOP after START: command=011.
- scl=0 and sda=0 for cycles 0-3;
- scl=1 at cycle 4;
- sda=1 at cycle 8;
- finish at cycle 16.
REQ-026 DATA0 (100), then DATA1 (101).
- scl is high during cycles 4-11 of each operation;
- sda is stable at 0 for DATA0 and at 1 for DATA1 throughout;
- each operation asserts finish at cycle 16.
REQ-027 ACK (110), then NACK (111).
- The waveform matches DATA0 and DATA1 respectively;
- every handshake follows go high -> finish high -> go low -> finish low.
REQ-028 Reset mid-op: assert reset_n=0 at cycle 6 of a DATA0 operation.
- scl=1, sda=1 and finish=0 immediately (asynchronous);
- a new command=010 after release runs normally.
REQ-029 Invalid command 000 with the macro defined.
- finish=1 and cmd_err=1 one edge after acceptance;
- scl and sda are unchanged;
- cmd_err clears with finish after go=0.

Source files
------------

// File: rtl/i2c_master_write_bit.sv
// I2C master single-bit writer: START, STOP, data and ACK/NACK bits.
// Optional cmd_err output enabled by defining I2C_WRITE_BIT_CMD_ERR_EN.
module i2c_master_write_bit #(
  parameter int unsigned QUARTER = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [2:0] command,
  output logic       finish,
  output logic       scl,
  output logic       sda
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
  ,
  output logic       cmd_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] C_START = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b011;
  localparam logic [7:0] LAST    = 8'(QUARTER - 1);

  state_t     state;
  logic [1:0] phase;
  logic [7:0] div;
  logic [2:0] cmd;
  logic       valid;

  // {scl, sda} for a given command and quarter phase
  function automatic logic [1:0] levels(
    input logic [2:0] c,
    input logic [1:0] p
  );
    logic [1:0] lv;
    lv = 2'b11;
    unique case (1'b1)
      (c == C_START): lv = {p != 2'd3, p < 2'd2};
      (c == C_STOP):  lv = {p != 2'd0, p[1]};
      default:        lv = {p == 2'd1 || p == 2'd2, c[0]};
    endcase
    return lv;
  endfunction

  // 000 and 001 are the only unusable encodings
  assign valid = command[2] | command[1];

  // Control FSM with quarter-bit divider and registered bus levels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      phase   <= 2'd0;
      div     <= 8'd0;
      cmd     <= 3'd0;
      finish  <= 1'b0;
      scl     <= 1'b1;
      sda     <= 1'b1;
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
      cmd_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            if (valid) begin
              cmd        <= command;
              state      <= RUN;
              phase      <= 2'd0;
              div        <= 8'd0;
              {scl, sda} <= levels(command, 2'd0);
            end else begin
              state   <= DONE;
              finish  <= 1'b1;
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
              cmd_err <= 1'b1;
`endif
            end
          end
        end
        RUN: begin
          if (div == LAST) begin
            div <= 8'd0;
            if (phase == 2'd3) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              phase      <= phase + 2'd1;
              {scl, sda} <= levels(cmd, phase + 2'd1);
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        DONE: begin
          if (!go) begin
            state   <= IDLE;
            finish  <= 1'b0;
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
            cmd_err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_write_bit.sv
// Directed bench for i2c_master_write_bit with QUARTER=4.
// Also checks cmd_err when I2C_WRITE_BIT_CMD_ERR_EN is defined.
module tb_i2c_master_write_bit;

  logic       clock;
  logic       reset_n;
  logic       go;
  logic [2:0] command;
  logic       finish;
  logic       scl;
  logic       sda;
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
  logic       cmd_err;
`endif

  int errors = 0;
  int checks = 0;

  logic w_scl [0:16];
  logic w_sda [0:16];
  logic w_fin [0:16];

  i2c_master_write_bit #(.QUARTER(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .command (command),
    .finish  (finish),
    .scl     (scl),
    .sda     (sda)
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
    ,
    .cmd_err (cmd_err)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch an operation and record cycles 0..16 (no checking here)
  task automatic run(
    input logic [2:0] c,
    input bit         drop,
    input logic [2:0] c2
  );
    command = c;
    go = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      w_scl[i] = scl;
      w_sda[i] = sda;
      w_fin[i] = finish;
      if (i == 2) command = c2;
      if (drop && i == 5) go = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    go = 1'b0;
    command = 3'b000;
    #23;
    checks++;
    if ({scl, sda, finish} !== 3'b110) begin
      errors++;
      $display("FAIL reset scl/sda/fin got %b%b%b want 110",
               scl, sda, finish);
    end
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset cmd_err got %b want 0", cmd_err);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_hold();
    go = 1'b0;
    command = 3'b101;
    repeat (3) tick();
    checks++;
    if ({scl, sda, finish} !== 3'b110) begin
      errors++;
      $display("FAIL idle_hold got %b%b%b want 110",
               scl, sda, finish);
    end
  endtask

  task automatic test_start();
    logic [3:0] ps;
    logic [3:0] pd;
    int p;
    ps = 4'b1110;
    pd = 4'b1100;
    run(3'b010, 1'b0, 3'b010);
    for (int i = 0; i <= 16; i++) begin
      p = (i > 15) ? 3 : i / 4;
      checks++;
      if ({w_scl[i], w_sda[i], w_fin[i]} !==
          {ps[3-p], pd[3-p], i == 16}) begin
        errors++;
        $display("FAIL start c%0d got %b%b%b want %b%b%b", i,
                 w_scl[i], w_sda[i], w_fin[i],
                 ps[3-p], pd[3-p], i == 16);
      end
    end
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b001) begin
      errors++;
      $display("FAIL start_held got %b%b%b want 001",
               scl, sda, finish);
    end
    go = 1'b0;
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b000) begin
      errors++;
      $display("FAIL start_release got %b%b%b want 000",
               scl, sda, finish);
    end
  endtask

  task automatic test_stop();
    logic [3:0] ps;
    logic [3:0] pd;
    int p;
    ps = 4'b0111;
    pd = 4'b0011;
    run(3'b011, 1'b0, 3'b011);
    for (int i = 0; i <= 16; i++) begin
      p = (i > 15) ? 3 : i / 4;
      checks++;
      if ({w_scl[i], w_sda[i], w_fin[i]} !==
          {ps[3-p], pd[3-p], i == 16}) begin
        errors++;
        $display("FAIL stop c%0d got %b%b%b want %b%b%b", i,
                 w_scl[i], w_sda[i], w_fin[i],
                 ps[3-p], pd[3-p], i == 16);
      end
    end
    go = 1'b0;
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b110) begin
      errors++;
      $display("FAIL stop_release got %b%b%b want 110",
               scl, sda, finish);
    end
  endtask

  // DATA0 (command changed mid-op, must be ignored) then DATA1
  task automatic test_data();
    logic [3:0] ps;
    logic       b;
    int p;
    ps = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      b = (k == 1);
      run({2'b10, b}, 1'b0, {2'b10, ~b});
      for (int i = 0; i <= 16; i++) begin
        p = (i > 15) ? 3 : i / 4;
        checks++;
        if ({w_scl[i], w_sda[i], w_fin[i]} !==
            {ps[3-p], b, i == 16}) begin
          errors++;
          $display("FAIL data%0d c%0d got %b%b%b want %b%b%b",
                   k, i, w_scl[i], w_sda[i], w_fin[i],
                   ps[3-p], b, i == 16);
        end
      end
      go = 1'b0;
      tick();
      checks++;
      if ({scl, sda, finish} !== {2'b00 | b, 1'b0}) begin
        errors++;
        $display("FAIL data%0d_release got %b%b%b want 0%b0",
                 k, scl, sda, finish, b);
      end
    end
  endtask

  task automatic test_ack();
    logic [3:0] ps;
    logic       b;
    int p;
    ps = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      b = (k == 1);
      run({2'b11, b}, 1'b0, {2'b11, b});
      for (int i = 0; i <= 16; i++) begin
        p = (i > 15) ? 3 : i / 4;
        checks++;
        if ({w_scl[i], w_sda[i], w_fin[i]} !==
            {ps[3-p], b, i == 16}) begin
          errors++;
          $display("FAIL ack%0d c%0d got %b%b%b want %b%b%b",
                   k, i, w_scl[i], w_sda[i], w_fin[i],
                   ps[3-p], b, i == 16);
        end
      end
      tick();
      checks++;
      if (finish !== 1'b1) begin
        errors++;
        $display("FAIL ack%0d_held fin got %b want 1", k, finish);
      end
      go = 1'b0;
      tick();
      checks++;
      if (finish !== 1'b0) begin
        errors++;
        $display("FAIL ack%0d_release fin got %b want 0", k, finish);
      end
    end
  endtask

  task automatic test_go_drop();
    run(3'b101, 1'b1, 3'b101);
    checks++;
    if ({w_fin[15], w_fin[16]} !== 2'b01) begin
      errors++;
      $display("FAIL go_drop fin15/16 got %b%b want 01",
               w_fin[15], w_fin[16]);
    end
    checks++;
    if ({w_scl[6], w_sda[6]} !== 2'b11) begin
      errors++;
      $display("FAIL go_drop c6 got %b%b want 11",
               w_scl[6], w_sda[6]);
    end
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b010) begin
      errors++;
      $display("FAIL go_drop_pulse got %b%b%b want 010",
               scl, sda, finish);
    end
  endtask

  // Bus is at scl=0 sda=1 from the previous DATA1
  task automatic test_invalid();
    command = 3'b000;
    go = 1'b1;
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b011) begin
      errors++;
      $display("FAIL invalid got %b%b%b want 011",
               scl, sda, finish);
    end
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL invalid cmd_err got %b want 1", cmd_err);
    end
`endif
    go = 1'b0;
    tick();
    checks++;
    if ({scl, sda, finish} !== 3'b010) begin
      errors++;
      $display("FAIL invalid_release got %b%b%b want 010",
               scl, sda, finish);
    end
`ifdef I2C_WRITE_BIT_CMD_ERR_EN
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_release cmd_err got %b want 0", cmd_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] ps;
    logic [3:0] pd;
    int p;
    command = 3'b100;
    go = 1'b1;
    repeat (7) tick();
    checks++;
    if ({scl, sda, finish} !== 3'b100) begin
      errors++;
      $display("FAIL mid_pre got %b%b%b want 100",
               scl, sda, finish);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({scl, sda, finish} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset got %b%b%b want 110",
               scl, sda, finish);
    end
    go = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ps = 4'b1110;
    pd = 4'b1100;
    run(3'b010, 1'b0, 3'b010);
    for (int i = 0; i <= 16; i++) begin
      p = (i > 15) ? 3 : i / 4;
      checks++;
      if ({w_scl[i], w_sda[i], w_fin[i]} !==
          {ps[3-p], pd[3-p], i == 16}) begin
        errors++;
        $display("FAIL mid_start c%0d got %b%b%b want %b%b%b", i,
                 w_scl[i], w_sda[i], w_fin[i],
                 ps[3-p], pd[3-p], i == 16);
      end
    end
    go = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_start();
    test_stop();
    test_data();
    test_ack();
    test_go_drop();
    test_invalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
